// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX; one quotient bit per
// cycle, holding the pipeline through stallreq_o until the result is ready.
`timescale 1ns/1ps
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     work_q, work_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 negQuot_q, negQuot_d;
  logic                 negRem_q, negRem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     op1Mag, op2Mag;
  logic [WIDTH+1:0]     trial;
  logic [2*WIDTH:0]     stepped;
  logic [WIDTH-1:0]     quot, rem, finalQuot, finalRem;
  logic                 lastStep;

  // Signed operands are divided as magnitudes; signs are reapplied at the end.
  assign op1Mag = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2Mag = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign trial   = work_q[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
  assign stepped = trial[WIDTH+1] ? {work_q[2*WIDTH-1:0], 1'b0}
                                  : {trial[WIDTH:0], work_q[WIDTH-2:0], 1'b1};

  assign quot      = stepped[WIDTH-1:0];
  assign rem       = stepped[2*WIDTH-1:WIDTH];
  assign finalQuot = negQuot_q ? -quot : quot;
  assign finalRem  = negRem_q ? -rem : rem;
  assign lastStep  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Flush wins over everything; dropping start_i mid-divide abandons it.
  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = (opdata2_i == '0) ? BY_ZERO : ON;
        BY_ZERO: state_d = END;
        ON: begin
          if (!start_i)     state_d = IDLE;
          else if (lastStep) state_d = END;
        end
        END:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;
    result_d  = '0;
    ready_d   = 1'b0;
    if (!annul_i) begin
      case (state_q)
        IDLE: begin
          if (start_i && (opdata2_i != '0)) begin
            work_d    = {{(WIDTH+1){1'b0}}, op1Mag};
            divisor_d = op2Mag;
            cnt_d     = '0;
            negQuot_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            negRem_d  = signed_i & opdata1_i[WIDTH-1];
          end
        end
        BY_ZERO: ready_d = 1'b1;
        ON: begin
          if (start_i) begin
            work_d = stepped;
            cnt_d  = cnt_q + CW'(1);
            if (lastStep) begin
              ready_d  = 1'b1;
              result_d = {finalRem, finalQuot};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i && !ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: cycle-exact latency, stall, result and flush checks.
`timescale 1ns/1ps
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int assertCount = 0;
  int failCount   = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic start, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic annul);
    start_i   = start;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    annul_i   = annul;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide at the current cycle and checks every cycle up to END.
  task automatic runDivide(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expRes, input int lat);
    applyStimulus(1'b1, sgn, a, b, 1'b0);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      checkOutput({tag, "_ready"}, {63'd0, ready_o}, {63'd0, c == lat});
      checkOutput({tag, "_stall"}, {63'd0, stallreq_o}, {63'd0, c != lat});
      checkOutput({tag, "_result"}, result_o, (c == lat) ? expRes : 64'd0);
      nextCycle();
    end
  endtask

  task automatic checkIdle(input string tag);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_idle_ready"}, {63'd0, ready_o}, 64'd0);
    checkOutput({tag, "_idle_result"}, result_o, 64'd0);
    nextCycle();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    checkOutput("reset_stall", {63'd0, stallreq_o}, 64'd0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    runDivide("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    checkIdle("divu_100_7");

    runDivide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    checkIdle("div_m7_2");
    runDivide("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    checkIdle("div_7_m2");
    runDivide("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
    checkIdle("div_m100_m7");

    runDivide("div_by0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
    checkIdle("div_by0");
    runDivide("divu_by0", 1'b0, 32'hFFFF_FFFF, 32'd0, 64'd0, 2);
    checkIdle("divu_by0");

    runDivide("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    checkIdle("div_ovf");
    runDivide("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
    checkIdle("divu_max_1");

    // Flush at cycle 10; a stale completion would show up at cycle 33.
    applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b0);
    for (int c = 0; c < 10; c++) nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd50, 32'd5, 1'b1);
    @(negedge clk);
    checkOutput("annul_stall", {63'd0, stallreq_o}, 64'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("annul_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("annul_result", result_o, 64'd0);
    nextCycle();
    runDivide("after_annul", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
    checkIdle("after_annul");

    applyStimulus(1'b1, 1'b0, 32'd81, 32'd9, 1'b0);
    for (int c = 0; c < 5; c++) nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd81, 32'd9, 1'b0);
    @(negedge clk);
    checkOutput("drop_stall", {63'd0, stallreq_o}, 64'd0);
    nextCycle();
    runDivide("after_drop", 1'b0, 32'd81, 32'd9, {32'd0, 32'd9}, 33);
    checkIdle("after_drop");

    runDivide("b2b_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    runDivide("b2b_10_4", 1'b0, 32'd10, 32'd4, {32'd2, 32'd2}, 33);
    checkIdle("b2b_10_4");

    // Reset mid-divide must abort it and leave the FSM idle.
    applyStimulus(1'b1, 1'b0, 32'd20, 32'd3, 1'b0);
    for (int c = 0; c < 5; c++) nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("rst_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("rst_result", result_o, 64'd0);
    checkOutput("rst_stall", {63'd0, stallreq_o}, 64'd0);
    nextCycle();
    runDivide("post_rst_by0", 1'b0, 32'd7, 32'd0, 64'd0, 2);
    checkIdle("post_rst_by0");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
